// File: rtl/instruction_memory_block_reader_if.sv
// Block-read handshake between the instruction cache (master) and the
// instruction memory (slave): request, block address, block data, busywait.
interface instruction_memory_block_reader_if;
    logic         read;
    logic [5:0]   address;
    logic [127:0] readdata;
    logic         busywait;

    modport master (
        output read,
        output address,
        input  readdata,
        input  busywait
    );

    modport slave (
        input  read,
        input  address,
        output readdata,
        output busywait
    );
endinterface

// File: rtl/instruction_memory_block_reader.sv
// Instruction memory responding to cache block-read misses after a fixed latency,
// with a word-wide program-load port for filling the array before execution.
module instruction_memory_block_reader #(
    parameter int READ_LATENCY = 5,
    parameter int NUM_BLOCKS   = 64
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    instruction_memory_block_reader_if.slave   mem_if,
    input  logic                               prog_write_i,
    input  logic [7:0]                         prog_addr_i,
    input  logic [31:0]                        prog_data_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     count_q, count_d;
    logic [5:0]     req_addr_q, req_addr_d;
    logic [127:0]   readdata_q, readdata_d;
    logic [127:0]   mem_q [NUM_BLOCKS];

    // Busywait must rise combinationally with read so the cache never sees a stale low.
    assign mem_if.busywait = (state_q == S_WAIT) || ((state_q == S_IDLE) && mem_if.read);
    assign mem_if.readdata = readdata_q;

    // Next-state, latency counter and block-load decisions.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        req_addr_d = req_addr_q;
        readdata_d = readdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_if.read) begin
                    req_addr_d = mem_if.address;
                    if (READ_LATENCY == 1) begin
                        readdata_d = mem_q[mem_if.address];
                        state_d    = S_DONE;
                    end else begin
                        count_d = 6'(READ_LATENCY - 1);
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!mem_if.read) begin
                    state_d = S_IDLE;
                end else if (count_q == 6'd0) begin
                    // mem_q still holds pre-write contents on a colliding program-load edge.
                    readdata_d = mem_q[req_addr_q];
                    state_d    = S_DONE;
                end else begin
                    count_d = count_q - 6'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any pending request.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            count_q    <= 6'd0;
            req_addr_q <= 6'd0;
            readdata_q <= 128'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            req_addr_q <= req_addr_d;
            readdata_q <= readdata_d;
        end
    end

    // Program-load word writes; the array survives reset.
    always_ff @(posedge clock_i) begin
        if (prog_write_i) begin
            mem_q[prog_addr_i[7:2]][{prog_addr_i[1:0], 5'd0} +: 32] <= prog_data_i;
        end
    end

endmodule
